cfg_regfile_shadowed: RTL and testbench
=======================================

Name: cfg_regfile_shadowed

Overview:
Parametrised configuration register file that receives commands from the UART command decoder. It holds NUM_REGS registers of DATA_W bits, such as baud select and pixel-ratio/position. Writes land in a shadow copy. The shadow copy is applied to the active outputs only on an apply strobe (e.g. VGA frame boundary), so a mid-frame write never glitches timing. It generalises the fixed two-register clock register file with explicit read/write, error responses, read-only registers and atomic commit.

Parameters:
NUM_REGS, 2, number of registers; register i (0-based) lives at address i+1.
ADDR_W, 4, command address width; require NUM_REGS <= 2**ADDR_W - 1.
DATA_W, 4, register width.
RESET_VALS, {4'h0,4'h1}, NUM_REGS*DATA_W packed reset values; register i is in slice [i*DATA_W +: DATA_W].
RO_MASK, 0, NUM_REGS bits; bit i=1 makes register i read-only.
SHADOWED, 1, 1 = writes wait for apply; 0 = writes go straight to active.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command strobe
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  0=soft reset, 1..NUM_REGS=register
cmd_data  in  DATA_W  write data
apply  in  1  single-cycle commit strobe
ack  out  1  one-cycle command acknowledge
err  out  1  valid with ack; command rejected
rd_data  out  DATA_W  read data, valid with rd_valid, else 0
rd_valid  out  1  one-cycle read response
pending  out  1  shadow differs from active (uncommitted write)
cfg_active  out  NUM_REGS*DATA_W  active register values, packed like RESET_VALS

Behaviour:
- Reset: shadow=active=RESET_VALS. ack=err=rd_valid=pending=0. rd_data=0. FSM=IDLE.
- FSM IDLE: a command is accepted when cmd_valid=1. Go to RESP.
- FSM RESP: lasts exactly one cycle, then returns to IDLE. cmd_valid is ignored in RESP; the command is dropped, not queued.
- Acknowledge timing: ack, err, rd_valid and rd_data are registered. They are high/valid for the single cycle after acceptance, then cleared to 0.
- Max throughput: one command every 2 cycles.
- Write to addr k (1..NUM_REGS), RO_MASK[k-1]=0: shadow[k-1] <= cmd_data. pending <= 1 when SHADOWED=1. When SHADOWED=0, active is also written the same edge.
- Read of addr k: rd_data = shadow[k-1], rd_valid=1, err=0.
- Soft reset (addr 0, read or write): shadow and active <= RESET_VALS, pending <= 0, ack=1, err=0, rd_valid=0.
- Error cases: addr > NUM_REGS, or a write to a read-only register. Response is ack=1, err=1, rd_valid=0, no state change. A read of a read-only register is legal.
- apply=1 (any FSM state): active <= shadow, pending <= 0. A write accepted in the same cycle commits the pre-write shadow value, and its new value leaves pending=1. A soft reset in the same cycle as apply wins.
- apply while pending=0: no effect.
- rst mid-response: everything returns to reset values immediately; the pending response is lost.
- cfg_active is driven directly from the active flops (no combinational path from cmd_*).

Decomposition:
- Shared package: FSM state encodings (IDLE, RESP), reserved address constant ADDR_SOFT_RST=0, default baud reset value.
- Sub-module: cfg_cmd_fsm, covering the accept/RESP handshake and ack/err/rd_valid generation. The register array stays in the top module.

Test Plan:
- Reset then idle: cfg_active=8'h01, pending=0, ack=0. Read addr 1 -> one cycle later ack=1, rd_valid=1, rd_data=4'h1.
- Write addr 2 data 4'h9 -> ack=1, err=0, pending=1, cfg_active still 8'h01. Pulse apply -> cfg_active=8'h91, pending=0.
- Back-to-back: cmd_valid held 3 cycles with writes 4'h3, 4'h4, 4'h5 to addr 1 -> only the 1st and 3rd are accepted. Shadow reg0 ends 4'h5, two ack pulses.
- Write addr 3 (NUM_REGS=2) -> ack=1, err=1, no change. With RO_MASK=2'b01, write addr 1 -> err=1, reg0 unchanged. Read addr 1 -> err=0.
- Write addr 1 = 4'h7 in the same cycle as apply -> active reg0 keeps its old value, pending=1. The next apply gives reg0=4'h7.
- After a pending write, soft reset + apply in the same cycle -> cfg_active=8'h01, pending=0. Assert rst during RESP -> ack=0 the next cycle.

Source files
------------

// File: rtl/cfg_regfile_shadowed_pkg.sv
// cfg_regfile_shadowed_pkg: shared FSM encodings and address/reset constants for the shadowed config register file
package cfg_regfile_shadowed_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } cmd_state_t;

    localparam int ADDR_SOFT_RST = 0;

    localparam logic [3:0] BAUD_RST_VAL = 4'h1;

endpackage

// File: rtl/cfg_cmd_fsm.sv
// cfg_cmd_fsm: accepts one command per two cycles, decodes it and produces the registered ack/err/read response
module cfg_cmd_fsm
    import cfg_regfile_shadowed_pkg::*;
#(
    parameter int                  NUM_REGS = 2,
    parameter int                  ADDR_W   = 4,
    parameter int                  DATA_W   = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_rd_word,
    output logic              o_wr_en,
    output logic              o_srst,
    output logic              o_ack,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS);

    cmd_state_t r_state;
    cmd_state_t w_state_nxt;
    logic       w_accept;
    logic       w_is_srst;
    logic       w_ro_hit;
    logic       w_bad;
    logic       w_rd_en;

    // Flag a command that targets a read-only register
    always_comb begin
        w_ro_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (RO_MASK[i] && i_cmd_addr == ADDR_W'(i + 1)) w_ro_hit = 1'b1;
    end

    assign w_accept  = (r_state == ST_IDLE) && i_cmd_valid;
    assign w_is_srst = i_cmd_addr == ADDR_W'(ADDR_SOFT_RST);
    assign w_bad     = (i_cmd_addr > LAST_ADDR) || (i_cmd_write && w_ro_hit);
    assign w_rd_en   = w_accept && !i_cmd_write && !w_is_srst && !w_bad;
    assign o_wr_en   = w_accept && i_cmd_write && !w_is_srst && !w_bad;
    assign o_srst    = w_accept && w_is_srst;

    // RESP always lasts one cycle; commands arriving then are dropped
    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = (r_state == ST_RESP) ? ST_IDLE : (w_accept ? ST_RESP : ST_IDLE);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Response flags are valid for exactly the cycle after acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_ack      <= 1'b0;
            o_err      <= 1'b0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            o_ack      <= w_accept;
            o_err      <= w_accept && w_bad;
            o_rd_valid <= w_rd_en;
            o_rd_data  <= w_rd_en ? i_rd_word : '0;
        end
    end

endmodule

// File: rtl/cfg_regfile_shadowed.sv
// cfg_regfile_shadowed: config register file whose writes land in a shadow copy and reach the outputs on apply
module cfg_regfile_shadowed
    import cfg_regfile_shadowed_pkg::*;
#(
    parameter int                         NUM_REGS   = 2,
    parameter int                         ADDR_W     = 4,
    parameter int                         DATA_W     = 4,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = {4'h0, BAUD_RST_VAL},
    parameter logic [NUM_REGS-1:0]        RO_MASK    = '0,
    parameter int                         SHADOWED   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_cmd_valid,
    input  logic                       i_cmd_write,
    input  logic [ADDR_W-1:0]          i_cmd_addr,
    input  logic [DATA_W-1:0]          i_cmd_data,
    input  logic                       i_apply,
    output logic                       o_ack,
    output logic                       o_err,
    output logic [DATA_W-1:0]          o_rd_data,
    output logic                       o_rd_valid,
    output logic                       o_pending,
    output logic [NUM_REGS*DATA_W-1:0] o_cfg_active
);

    if (NUM_REGS > (2 ** ADDR_W) - 1) begin : g_bad_cfg
        $error("NUM_REGS does not fit in the command address space");
    end

    logic [NUM_REGS*DATA_W-1:0] r_shadow;
    logic [NUM_REGS*DATA_W-1:0] r_active;
    logic                       r_pending;
    logic [DATA_W-1:0]          w_rd_word;
    logic                       w_wr_en;
    logic                       w_srst;

    cfg_cmd_fsm #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RO_MASK  (RO_MASK)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd_write (i_cmd_write),
        .i_cmd_addr  (i_cmd_addr),
        .i_rd_word   (w_rd_word),
        .o_wr_en     (w_wr_en),
        .o_srst      (w_srst),
        .o_ack       (o_ack),
        .o_err       (o_err),
        .o_rd_data   (o_rd_data),
        .o_rd_valid  (o_rd_valid)
    );

    // Reads return the shadow copy so software sees what it last wrote
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (i_cmd_addr == ADDR_W'(i + 1)) w_rd_word = r_shadow[i*DATA_W +: DATA_W];
    end

    // Soft reset beats apply; apply copies the pre-write shadow, so a same-cycle write stays pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow  <= RESET_VALS;
            r_active  <= RESET_VALS;
            r_pending <= 1'b0;
        end else if (w_srst) begin
            r_shadow  <= RESET_VALS;
            r_active  <= RESET_VALS;
            r_pending <= 1'b0;
        end else begin
            if (i_apply) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
            for (int i = 0; i < NUM_REGS; i++)
                if (w_wr_en && i_cmd_addr == ADDR_W'(i + 1)) begin
                    r_shadow[i*DATA_W +: DATA_W] <= i_cmd_data;
                    if (SHADOWED != 0) r_pending <= 1'b1;
                    else               r_active[i*DATA_W +: DATA_W] <= i_cmd_data;
                end
        end
    end

    assign o_pending    = r_pending;
    assign o_cfg_active = r_active;

endmodule

// File: tb/tb_cfg_regfile_shadowed.sv
// tb_cfg_regfile_shadowed: directed checks of a shadowed instance and a read-only/unshadowed instance
module tb_cfg_regfile_shadowed;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 0, a_write = 0, a_apply = 0;
    logic [3:0] a_addr = 0, a_data = 0;
    logic       a_ack, a_err, a_rd_valid, a_pending;
    logic [3:0] a_rd_data;
    logic [7:0] a_cfg;
    logic       b_valid = 0, b_write = 0, b_apply = 0;
    logic [3:0] b_addr = 0, b_data = 0;
    logic       b_ack, b_err, b_rd_valid, b_pending;
    logic [3:0] b_rd_data;
    logic [7:0] b_cfg;
    int         n_run = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    cfg_regfile_shadowed u_a (
        .clk(clk), .rst(rst), .i_cmd_valid(a_valid), .i_cmd_write(a_write), .i_cmd_addr(a_addr),
        .i_cmd_data(a_data), .i_apply(a_apply), .o_ack(a_ack), .o_err(a_err), .o_rd_data(a_rd_data),
        .o_rd_valid(a_rd_valid), .o_pending(a_pending), .o_cfg_active(a_cfg)
    );

    cfg_regfile_shadowed #(.RO_MASK(2'b01), .SHADOWED(0)) u_b (
        .clk(clk), .rst(rst), .i_cmd_valid(b_valid), .i_cmd_write(b_write), .i_cmd_addr(b_addr),
        .i_cmd_data(b_data), .i_apply(b_apply), .o_ack(b_ack), .o_err(b_err), .o_rd_data(b_rd_data),
        .o_rd_valid(b_rd_valid), .o_pending(b_pending), .o_cfg_active(b_cfg)
    );

    task automatic issue(input bit sel, input bit w, input logic [3:0] ad, input logic [3:0] d, input bit ap);
        @(negedge clk);
        if (!sel) begin a_valid = 1; a_write = w; a_addr = ad; a_data = d; a_apply = ap; end
        else      begin b_valid = 1; b_write = w; b_addr = ad; b_data = d; b_apply = ap; end
        @(negedge clk);
        a_valid = 0; a_apply = 0; b_valid = 0; b_apply = 0;
    endtask

    task automatic pulse_apply();
        @(negedge clk); a_apply = 1;
        @(negedge clk); a_apply = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        n_run++; if (a_cfg !== 8'h01) begin n_fail++; $display("FAIL reset_cfg got %h exp 01", a_cfg); end
        n_run++; if ({a_ack, a_err, a_rd_valid, a_pending} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {a_ack, a_err, a_rd_valid, a_pending}); end
        n_run++; if (a_rd_data !== 4'h0) begin n_fail++; $display("FAIL reset_rd_data got %h exp 0", a_rd_data); end
        n_run++; if (b_cfg !== 8'h01) begin n_fail++; $display("FAIL reset_cfg_b got %h exp 01", b_cfg); end
    endtask

    task automatic test_read();
        issue(0, 0, 4'd1, 4'h0, 0);
        n_run++; if ({a_ack, a_err, a_rd_valid} !== 3'b101) begin n_fail++; $display("FAIL read_flags got %b exp 101", {a_ack, a_err, a_rd_valid}); end
        n_run++; if (a_rd_data !== 4'h1) begin n_fail++; $display("FAIL read_data got %h exp 1", a_rd_data); end
        @(negedge clk);
        n_run++; if ({a_ack, a_rd_valid, a_rd_data} !== 6'b0) begin n_fail++; $display("FAIL read_clear got %b exp 000000", {a_ack, a_rd_valid, a_rd_data}); end
    endtask

    task automatic test_write_apply();
        issue(0, 1, 4'd2, 4'h9, 0);
        n_run++; if ({a_ack, a_err, a_pending} !== 3'b101) begin n_fail++; $display("FAIL wr_flags got %b exp 101", {a_ack, a_err, a_pending}); end
        n_run++; if (a_cfg !== 8'h01) begin n_fail++; $display("FAIL wr_active_held got %h exp 01", a_cfg); end
        pulse_apply();
        n_run++; if (a_cfg !== 8'h91 || a_pending !== 1'b0) begin n_fail++; $display("FAIL apply got cfg %h pend %b exp 91 0", a_cfg, a_pending); end
        pulse_apply();
        n_run++; if (a_cfg !== 8'h91 || a_pending !== 1'b0) begin n_fail++; $display("FAIL apply_idle got cfg %h pend %b exp 91 0", a_cfg, a_pending); end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        @(negedge clk); a_valid = 1; a_write = 1; a_addr = 4'd1; a_data = 4'h3;
        @(negedge clk); a_data = 4'h4; acks += int'(a_ack);
        @(negedge clk); a_data = 4'h5; acks += int'(a_ack);
        @(negedge clk); a_valid = 0; acks += int'(a_ack);
        @(negedge clk); acks += int'(a_ack);
        n_run++; if (acks !== 2) begin n_fail++; $display("FAIL b2b_acks got %0d exp 2", acks); end
        issue(0, 0, 4'd1, 4'h0, 0);
        n_run++; if (a_rd_data !== 4'h5) begin n_fail++; $display("FAIL b2b_shadow got %h exp 5", a_rd_data); end
        pulse_apply();
        n_run++; if (a_cfg !== 8'h95) begin n_fail++; $display("FAIL b2b_apply got %h exp 95", a_cfg); end
    endtask

    task automatic test_errors();
        issue(0, 1, 4'd3, 4'hF, 0);
        n_run++; if ({a_ack, a_err, a_rd_valid, a_pending} !== 4'b1100) begin n_fail++; $display("FAIL err_range_wr got %b exp 1100", {a_ack, a_err, a_rd_valid, a_pending}); end
        issue(0, 0, 4'd3, 4'h0, 0);
        n_run++; if ({a_ack, a_err, a_rd_valid} !== 3'b110) begin n_fail++; $display("FAIL err_range_rd got %b exp 110", {a_ack, a_err, a_rd_valid}); end
        pulse_apply();
        n_run++; if (a_cfg !== 8'h95) begin n_fail++; $display("FAIL err_no_change got %h exp 95", a_cfg); end
        issue(1, 1, 4'd1, 4'h6, 0);
        n_run++; if ({b_ack, b_err} !== 2'b11 || b_cfg !== 8'h01) begin n_fail++; $display("FAIL err_ro_wr got %b cfg %h exp 11 01", {b_ack, b_err}, b_cfg); end
        issue(1, 0, 4'd1, 4'h0, 0);
        n_run++; if ({b_ack, b_err, b_rd_valid, b_rd_data} !== 7'b1010001) begin n_fail++; $display("FAIL ro_read got %b exp 1010001", {b_ack, b_err, b_rd_valid, b_rd_data}); end
        issue(1, 1, 4'd2, 4'h7, 0);
        n_run++; if (b_cfg !== 8'h71 || b_pending !== 1'b0 || b_err !== 1'b0) begin n_fail++; $display("FAIL direct_wr got cfg %h pend %b err %b exp 71 0 0", b_cfg, b_pending, b_err); end
    endtask

    task automatic test_apply_collision();
        issue(0, 1, 4'd2, 4'h2, 0);
        issue(0, 1, 4'd1, 4'h7, 1);
        n_run++; if (a_cfg !== 8'h25 || a_pending !== 1'b1) begin n_fail++; $display("FAIL collide got cfg %h pend %b exp 25 1", a_cfg, a_pending); end
        pulse_apply();
        n_run++; if (a_cfg !== 8'h27 || a_pending !== 1'b0) begin n_fail++; $display("FAIL collide_commit got cfg %h pend %b exp 27 0", a_cfg, a_pending); end
    endtask

    task automatic test_soft_reset();
        issue(0, 1, 4'd2, 4'hA, 0);
        issue(0, 1, 4'd0, 4'h0, 1);
        n_run++; if ({a_ack, a_err, a_rd_valid} !== 3'b100) begin n_fail++; $display("FAIL srst_flags got %b exp 100", {a_ack, a_err, a_rd_valid}); end
        n_run++; if (a_cfg !== 8'h01 || a_pending !== 1'b0) begin n_fail++; $display("FAIL srst_apply got cfg %h pend %b exp 01 0", a_cfg, a_pending); end
        issue(0, 0, 4'd2, 4'h0, 0);
        n_run++; if (a_rd_data !== 4'h0 || a_rd_valid !== 1'b1) begin n_fail++; $display("FAIL srst_shadow got %h v %b exp 0 1", a_rd_data, a_rd_valid); end
        issue(1, 0, 4'd0, 4'h0, 0);
        n_run++; if (b_cfg !== 8'h01 || b_rd_valid !== 1'b0 || b_ack !== 1'b1) begin n_fail++; $display("FAIL srst_read got cfg %h v %b ack %b exp 01 0 1", b_cfg, b_rd_valid, b_ack); end
    endtask

    task automatic test_rst_mid_resp();
        @(negedge clk); a_valid = 1; a_write = 1; a_addr = 4'd2; a_data = 4'h3;
        @(posedge clk); #1 a_valid = 0;
        n_run++; if (a_ack !== 1'b1 || a_pending !== 1'b1) begin n_fail++; $display("FAIL pre_rst got ack %b pend %b exp 1 1", a_ack, a_pending); end
        #2 rst = 1;
        #1;
        n_run++; if (a_ack !== 1'b0 || a_pending !== 1'b0 || a_cfg !== 8'h01) begin n_fail++; $display("FAIL rst_mid got ack %b pend %b cfg %h exp 0 0 01", a_ack, a_pending, a_cfg); end
        @(negedge clk); rst = 0;
        @(negedge clk);
        n_run++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL rst_after got ack %b exp 0", a_ack); end
        issue(0, 0, 4'd2, 4'h0, 0);
        n_run++; if (a_rd_data !== 4'h0) begin n_fail++; $display("FAIL rst_shadow got %h exp 0", a_rd_data); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_apply();
        test_back_to_back();
        test_errors();
        test_apply_collision();
        test_soft_reset();
        test_rst_mid_resp();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
